// File: rtl/dmem_store_packer.sv
// Store-side data aligner: packs sb/sh/sw into lane-replicated write data with
// byte enables, buffers through a two-entry skid stage and tracks unacked writes.
module dmem_store_packer #(
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_addr,
    input  logic [31:0] in_data,
    input  logic [1:0]  in_size,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_addr,
    output logic [31:0] out_wdata,
    output logic [3:0]  out_be,
    input  logic        mem_ack,
    output logic        fault,
    output logic [31:0] fault_addr,
    output logic [2:0]  pending,
    output logic        idle
);

    logic [31:0] pack_wdata;
    logic [3:0]  pack_be;
    logic        misaligned;

    logic        skid_valid;
    logic [31:0] skid_addr;
    logic [31:0] skid_wdata;
    logic [3:0]  skid_be;

    logic        out_valid_d;
    logic [31:0] out_addr_d;
    logic [31:0] out_wdata_d;
    logic [3:0]  out_be_d;
    logic        skid_valid_d;
    logic [31:0] skid_addr_d;
    logic [31:0] skid_wdata_d;
    logic [3:0]  skid_be_d;
    logic [2:0]  pending_d;

    logic [1:0]  occupancy;
    logic [3:0]  in_flight;
    logic        accept;
    logic        push;
    logic        pop;
    logic        ack_eff;

    always_comb begin
        pack_wdata = '0;
        pack_be    = '0;
        misaligned = 1'b0;
        case (in_size)
            2'b00: begin
                pack_wdata = {4{in_data[7:0]}};
                pack_be    = 4'b0001 << in_addr[1:0];
            end
            2'b01: begin
                pack_wdata = {2{in_data[15:0]}};
                pack_be    = in_addr[1] ? 4'b1100 : 4'b0011;
                misaligned = in_addr[0];
            end
            2'b10: begin
                pack_wdata = in_data;
                pack_be    = 4'b1111;
                misaligned = (in_addr[1:0] != 2'b00);
            end
            default: begin
                misaligned = 1'b1;
            end
        endcase
    end

    // Credit counts both buffered entries and writes awaiting mem_ack.
    assign occupancy = {1'b0, out_valid} + {1'b0, skid_valid};
    assign in_flight = {1'b0, pending} + {2'b00, occupancy};
    assign in_ready  = !rst && (occupancy < 2'd2) && (in_flight < 4'(MAX_OUTSTANDING));

    assign accept  = in_valid && in_ready;
    assign push    = accept && !misaligned;
    assign pop     = out_valid && out_ready;
    assign ack_eff = mem_ack && (pending != 3'd0);
    assign idle    = !out_valid && !skid_valid && (pending == 3'd0);

    always_comb begin
        out_valid_d  = out_valid;
        out_addr_d   = out_addr;
        out_wdata_d  = out_wdata;
        out_be_d     = out_be;
        skid_valid_d = skid_valid;
        skid_addr_d  = skid_addr;
        skid_wdata_d = skid_wdata;
        skid_be_d    = skid_be;

        if (pop) begin
            if (skid_valid) begin
                // in_ready is low at occupancy 2, so no push can coincide here.
                out_addr_d   = skid_addr;
                out_wdata_d  = skid_wdata;
                out_be_d     = skid_be;
                skid_valid_d = 1'b0;
            end else if (push) begin
                out_addr_d  = {in_addr[31:2], 2'b00};
                out_wdata_d = pack_wdata;
                out_be_d    = pack_be;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (push) begin
            if (!out_valid) begin
                out_valid_d = 1'b1;
                out_addr_d  = {in_addr[31:2], 2'b00};
                out_wdata_d = pack_wdata;
                out_be_d    = pack_be;
            end else begin
                skid_valid_d = 1'b1;
                skid_addr_d  = {in_addr[31:2], 2'b00};
                skid_wdata_d = pack_wdata;
                skid_be_d    = pack_be;
            end
        end
    end

    always_comb begin
        pending_d = pending;
        if (pop && !ack_eff) begin
            pending_d = pending + 3'd1;
        end else if (!pop && ack_eff) begin
            pending_d = pending - 3'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_addr   <= '0;
            out_wdata  <= '0;
            out_be     <= '0;
            skid_valid <= 1'b0;
            skid_addr  <= '0;
            skid_wdata <= '0;
            skid_be    <= '0;
            pending    <= '0;
            fault      <= 1'b0;
            fault_addr <= '0;
        end else begin
            out_valid  <= out_valid_d;
            out_addr   <= out_addr_d;
            out_wdata  <= out_wdata_d;
            out_be     <= out_be_d;
            skid_valid <= skid_valid_d;
            skid_addr  <= skid_addr_d;
            skid_wdata <= skid_wdata_d;
            skid_be    <= skid_be_d;
            pending    <= pending_d;
            fault      <= accept && misaligned;
            if (accept && misaligned) begin
                fault_addr <= in_addr;
            end
        end
    end

endmodule
